// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// immediate formats, ALU codes and datapath mux selects.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_JAL      = 4'd8;
  localparam state_t S_ALUWB    = 4'd9;
  localparam state_t S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse aluop plus the instruction's funct fields onto the ALU
// operation code. Purely combinational so the single-cycle core can share it.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [2:0]           funct3,
  input  logic                 op5,
  input  logic                 funct7b5,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  // Only R-type (op5 set) may select subtract through funct7; addi never does.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch through
// writeback and drives every mux select and write enable of the datapath.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic                 adrsrc,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic [1:0]           resultsrc,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic                 regwrite,
  output logic [IMMSRC_W-1:0]  immsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  state_t state, next_state;
  aluop_t aluop;
  logic   pcupdate, branch;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Moore outputs per state, with fetch and memory stages gated by mem_ready.
  always_comb begin
    next_state = S_FETCH;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    regwrite   = 1'b0;
    aluop      = ALUOP_ADD;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        resultsrc  = RES_ALURESULT;
        irwrite    = mem_ready;
        pcupdate   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        pcupdate   = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign pcwrite = pcupdate | (branch & zero);

  always_comb begin
    case (op)
      OP_LW, OP_I: immsrc = IMM_I;
      OP_SW:       immsrc = IMM_S;
      OP_BEQ:      immsrc = IMM_B;
      OP_JAL:      immsrc = IMM_J;
      default:     immsrc = IMM_I;
    endcase
  end

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is modelled as a
// numbered sequence of datapath steps whose controls are derived from its class.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  // Model state: instruction class, its fields, and how far through it we are.
  int         m_cls;
  int         m_step;
  logic [2:0] m_f3;
  logic       m_f7, m_zero;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regwrite   (regwrite),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  function automatic int len_of(input int cls);
    case (cls)
      C_LW:    return 5;
      C_BEQ:   return 3;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Fetch, the lw read and the sw write are the only steps that wait on memory.
  function automatic bit waits_on_mem();
    return (m_step == 0) || (m_step == 3 && (m_cls == C_LW || m_cls == C_SW));
  endfunction

  function automatic logic [2:0] alu_fn();
    case (m_f3)
      3'b000:  return (m_cls == C_R && m_f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected {pcwrite,adrsrc,memwrite,irwrite,resultsrc,alusrca,alusrcb,regwrite,immsrc,alucontrol,illegal}.
  function automatic logic [16:0] model_out(input logic mr);
    logic       pw = 0, ad = 0, mw = 0, ir = 0, rw = 0, il = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, im = 0;
    logic [2:0] ac = 0;
    case (m_cls)
      C_SW:  im = 2'd1;
      C_BEQ: im = 2'd2;
      C_JAL: im = 2'd3;
      default: im = 2'd0;
    endcase
    if (m_step == 0) begin
      ir = mr; pw = mr; sb = 2'd2; rs = 2'd2;
    end else if (m_step == 1) begin
      sa = 2'd1; sb = 2'd1; il = (m_cls == C_ILL);
    end else begin
      case (m_cls)
        C_LW: begin
          if (m_step == 2) begin sa = 2'd2; sb = 2'd1; end
          else if (m_step == 3) ad = 1'b1;
          else begin rs = 2'd1; rw = 1'b1; end
        end
        C_SW: begin
          if (m_step == 2) begin sa = 2'd2; sb = 2'd1; end
          else begin ad = 1'b1; mw = 1'b1; end
        end
        C_R, C_I: begin
          if (m_step == 2) begin sa = 2'd2; sb = (m_cls == C_I) ? 2'd1 : 2'd0; ac = alu_fn(); end
          else rw = 1'b1;
        end
        C_JAL: begin
          if (m_step == 2) begin sa = 2'd1; sb = 2'd2; pw = 1'b1; end
          else rw = 1'b1;
        end
        C_BEQ: begin
          sa = 2'd2; ac = 3'd1; pw = m_zero;
        end
        default: ;
      endcase
    end
    return {pw, ad, mw, ir, rs, sa, sb, rw, im, ac, il};
  endfunction

  task automatic set_instr(input int cls, input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic z);
    m_cls = cls; m_f3 = f3; m_f7 = f7; m_zero = z; m_step = 0;
    op = opc; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  // One clock: sample outputs mid-cycle, then let the edge pass and advance the model.
  task automatic drive_cycle(input logic mr, output logic [16:0] obs, output logic [16:0] expv);
    mem_ready = mr;
    @(negedge clk);
    obs  = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
            regwrite, immsrc, alucontrol, illegal};
    expv = model_out(mr);
    @(posedge clk);
    #1;
    if (!(waits_on_mem() && !mr)) m_step++;
  endtask

  task automatic test_reset();
    logic [16:0] obs, expv;
    set_instr(C_LW, op_of(C_LW), 3'b010, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, obs, expv);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_hold got %h expected %h", obs, expv); end
    reset = 1'b0;
    drive_cycle(1'b0, obs, expv);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_release got %h expected %h", obs, expv); end
  endtask

  task automatic test_lw();
    logic [16:0] obs, expv;
    set_instr(C_LW, op_of(C_LW), 3'b010, 1'b0, 1'b0);
    while (m_step < len_of(C_LW)) begin
      drive_cycle(1'b1, obs, expv);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lw step%0d got %h expected %h", m_step - 1, obs, expv); end
    end
  endtask

  task automatic test_sw_stall();
    logic [16:0] obs, expv;
    int cyc = 0;
    int mw_cycles = 0;
    set_instr(C_SW, op_of(C_SW), 3'b010, 1'b1, 1'b0);
    while (m_step < len_of(C_SW) && cyc < 20) begin
      drive_cycle((cyc == 3 || cyc == 4) ? 1'b0 : 1'b1, obs, expv);
      cyc++;
      if (memwrite === 1'b1 || obs[14]) mw_cycles += obs[14] ? 1 : 0;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL sw_stall cycle%0d got %h expected %h", cyc - 1, obs, expv); end
    end
    checks++;
    if (mw_cycles !== 3) begin errors++; $display("FAIL sw_memwrite_len got %0d expected 3", mw_cycles); end
  endtask

  task automatic test_alu();
    logic [16:0] obs, expv;
    for (int k = 0; k < 3; k++) begin
      set_instr((k == 2) ? C_I : C_R, op_of((k == 2) ? C_I : C_R), 3'b000, (k != 1), 1'b0);
      while (m_step < 4) begin
        drive_cycle(1'b1, obs, expv);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL alu%0d step%0d got %h expected %h", k, m_step - 1, obs, expv); end
        if (m_step == 3) begin
          checks++;
          if (obs[3:1] !== ((k == 0) ? 3'd1 : 3'd0))
            begin errors++; $display("FAIL alu%0d_alucontrol got %0d expected %0d", k, obs[3:1], (k == 0) ? 1 : 0); end
        end
      end
    end
  endtask

  task automatic test_beq();
    logic [16:0] obs, expv;
    for (int z = 1; z >= 0; z--) begin
      set_instr(C_BEQ, op_of(C_BEQ), 3'b000, 1'b0, z[0]);
      while (m_step < len_of(C_BEQ)) begin
        drive_cycle(1'b1, obs, expv);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL beq_z%0d step%0d got %h expected %h", z, m_step - 1, obs, expv); end
      end
    end
  endtask

  task automatic test_jal_illegal();
    logic [16:0] obs, expv;
    for (int k = 0; k < 2; k++) begin
      set_instr(k == 0 ? C_JAL : C_ILL, op_of(k == 0 ? C_JAL : C_ILL), 3'b000, 1'b0, 1'b0);
      while (m_step < len_of(m_cls)) begin
        drive_cycle(1'b1, obs, expv);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL %s step%0d got %h expected %h", k == 0 ? "jal" : "illegal", m_step - 1, obs, expv); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] obs, expv;
    set_instr(C_SW, op_of(C_SW), 3'b010, 1'b0, 1'b0);
    while (m_step < 3) drive_cycle(1'b1, obs, expv);
    reset = 1'b1;
    drive_cycle(1'b0, obs, expv);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_mid_write got %h expected %h", obs, expv); end
    reset  = 1'b0;
    m_step = 0;
    drive_cycle(1'b0, obs, expv);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_mid_after got %h expected %h", obs, expv); end
    checks++;
    if ({memwrite, regwrite, illegal} !== 3'b000)
      begin errors++; $display("FAIL reset_mid_writes got %b expected 000", {memwrite, regwrite, illegal}); end
  endtask

  task automatic test_random();
    logic [16:0] obs, expv;
    logic [6:0]  opc;
    int          cls, cyc;
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 6);
      opc = op_of(cls);
      if (cls == C_ILL) begin
        do opc = 7'($urandom_range(0, 127));
        while (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b0110011 ||
               opc == 7'b0010011 || opc == 7'b1100011 || opc == 7'b1101111);
      end
      set_instr(cls, opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc = 0;
      while (m_step < len_of(cls)) begin
        drive_cycle((cyc > 30) ? 1'b1 : ($urandom_range(0, 3) != 0), obs, expv);
        cyc++;
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL random%0d cls%0d step%0d got %h expected %h", n, cls, m_step, obs, expv); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    m_cls = C_LW; m_step = 0; m_f3 = 3'd0; m_f7 = 1'b0; m_zero = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu();
    test_beq();
    test_jal_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU, register file and unified memory.
- Drives `immsrc` of the immediate generator, the ALU mux selects, `alucontrol` and all write enables.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Memory accesses stall on a ready handshake.

Parameters:
- ALUCTRL_W, 3, width of the `alucontrol` bus.
- IMMSRC_W, 2, width of the `immsrc` bus (fixed at 2 for the current imm generator).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- op  input  7  instr[6:0], sampled from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed the current access this cycle
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  data memory write strobe
- irwrite  output  1  instruction register / OldPC enable
- resultsrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- alusrca  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- alusrcb  output  2  ALU B select: 00 rs2, 01 ExtImm, 10 constant 4
- regwrite  output  1  register file write enable
- immsrc  output  2  imm format select: 00 I, 01 S, 10 B, 11 J
- alucontrol  output  3  ALU operation
- illegal  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- One clock, `clk`. `reset` is synchronous and active-high; while asserted the state is forced to FETCH on the next edge.
- Every output not listed for a state is 0. At reset release the state is FETCH with FETCH outputs.
- `illegal` resets to 0.
- All outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready (Moore plus mem_ready/zero gating). No output registers.
- `pcwrite` = pcupdate | (branch & zero).
- Unconditional `immsrc` decode from op:
  - 0000011 or 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all other opcodes -> 00
- States, with outputs and transitions:
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=mem_ready, pcupdate=mem_ready. Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (branch target precompute). Next state by op:
    - lw, sw -> MEMADR
    - R-type (0110011) -> EXECR
    - I-ALU -> EXECI
    - beq -> BEQ
    - jal -> JAL
    - other -> FETCH with illegal=1 for this cycle
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adrsrc=1, resultsrc=00. Holds until mem_ready, then -> MEMWB.
  - MEMWB: resultsrc=01, regwrite=1 -> FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1. Holds (memwrite held high) until mem_ready, then -> FETCH.
  - EXECR: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
  - EXECI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB.
  - ALUWB: resultsrc=00, regwrite=1 -> FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH.
- ALU decode:
  - aluop 00 -> add 000; aluop 01 -> sub 001.
  - aluop 10, by funct3:
    - 000 -> sub (001) if op[5]&funct7b5, else add (000)
    - 010 -> slt 101
    - 110 -> or 011
    - 111 -> and 010
    - others -> 000
- Latency with mem_ready always 1:
  - lw 5 cycles
  - sw, R-type, I-ALU, jal 4 cycles
  - beq 3 cycles
  - illegal 2 cycles
- Reset asserted mid-instruction:
  - Next state is FETCH.
  - No regwrite or memwrite is issued in the cycle after the reset edge.
  - Writes asserted combinationally during the reset cycle itself are permitted; the datapath register file and memory ignore them under reset.
- Unknown state encodings fall back to FETCH.

Decomposition:
- Shared package `ctrl_pkg`:
  - state enum (4 bits, 11 states)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - IMM_I/S/B/J encodings
  - ALU_ADD/SUB/AND/OR/SLT codes
  - aluop codes
  - resultsrc, alusrca and alusrcb encodings
- Sub-module `alu_decoder`: purely combinational; inputs aluop, funct3, op5, funct7b5; output alucontrol. Reused by the planned single-cycle variant.

Test Plan:
- lw (op 0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. immsrc=00. regwrite=1 only in cycle 5 with resultsrc=01.
- sw (0100011), mem_ready low for 2 cycles in MEMWRITE -> memwrite held high 3 cycles. immsrc=01. Returns to FETCH after mem_ready. regwrite never asserted.
- R-type sub (funct3=000, funct7b5=1) -> alucontrol=001 in EXECR. Same instruction with funct7b5=0 -> 000. I-type addi with funct7b5=1 -> 000 (op5=0).
- beq with zero=1 -> pcwrite=1 in BEQ, immsrc=10. With zero=0 -> pcwrite=0. Both back in FETCH on cycle 4.
- jal (1101111) -> immsrc=11, pcwrite=1 in JAL, regwrite=1 in ALUWB, resultsrc=00. Illegal op 1111111 -> illegal pulses 1 cycle in DECODE, then FETCH.
- reset asserted while in MEMWRITE with mem_ready=0 -> next cycle state FETCH, memwrite=0, illegal=0.
